// File: rtl/btn_debounce.sv
// Per-channel button synchroniser, debouncer, edge pulses and sticky move request.
// Define BTN_REPEAT_EN to enable hold-to-repeat press pulses.
module btn_debounce #(
    parameter int N_BTN         = 4,
    parameter int CNT_W         = 20,
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_n,
    input  logic [N_BTN-1:0] ack,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] move_pending,
    output logic             any_pending
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q, p;
    logic [N_BTN-1:0] state_q, state_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

`ifdef BTN_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] REP_AT = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] REP_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [N_BTN-1:0]  rep_q, rep_d;
    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
`else
    localparam int unused_rep = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    always_comb begin
        p       = ~sync2_q;
        state_d = state_q;
        press_d = '0;
        rel_d   = '0;
`ifdef BTN_REPEAT_EN
        rep_d   = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (p[i] != state_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    state_d[i] = p[i];
                    press_d[i] = p[i];
                    rel_d[i]   = ~p[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
`ifdef BTN_REPEAT_EN
            // Reload keeps the counter bounded: next fire is one period away.
            hold_d[i] = '0;
            if (state_q[i] && state_d[i]) begin
                hold_d[i] = hold_q[i] + 1'b1;
                if (hold_d[i] == REP_AT) begin
                    rep_d[i]   = 1'b1;
                    press_d[i] = 1'b1;
                    hold_d[i]  = REP_RELOAD;
                end
            end
`endif
        end
`ifdef BTN_REPEAT_EN
        pend_d = (pend_q & ~ack) | rel_q | rep_q;
`else
        pend_d = (pend_q & ~ack) | rel_q;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            pend_q  <= pend_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_q <= '0;
            for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
        end
    end
`endif

    assign btn_state     = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign move_pending  = pend_q;
    assign any_pending   = |pend_q;

endmodule
